// File: rtl/mem_pkg.sv
// Shared types for the memory-access pipeline stage: load kinds and stage FSM states.
package mem_pkg;

  typedef enum logic [2:0] {
    LD_B  = 3'd0,
    LD_H  = 3'd1,
    LD_W  = 3'd2,
    LD_D  = 3'd3,
    LD_BU = 3'd4,
    LD_HU = 3'd5,
    LD_WU = 3'd6
  } ld_op_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    WAIT  = 2'd1,
    FULL  = 2'd2
  } mem_state_e;

endpackage

// File: rtl/ld_align.sv
// Combinational lane select and sign/zero extension of a raw load response word.
module ld_align
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  localparam int unsigned OffW  = $clog2(DATA_W / 8)
) (
  input  ld_op_e            ld_op,
  input  logic [OffW-1:0]   addr,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] ext_data
);

  logic [7:0]        lane_b;
  logic [15:0]       lane_h;
  logic [31:0]       lane_w;
  logic [DATA_W-1:0] word_s;
  logic [DATA_W-1:0] word_u;

  // Address bits below the access size are dropped by the shift amounts.
  assign lane_b = 8'(rdata >> {addr, 3'b000});
  assign lane_h = 16'(rdata >> {addr[OffW-1:1], 4'b0000});

  if (DATA_W == 64) begin : g_w64
    assign lane_w = 32'(rdata >> {addr[OffW-1], 5'b00000});
    assign word_s = {{32{lane_w[31]}}, lane_w};
    assign word_u = {32'b0, lane_w};
  end else begin : g_w32
    assign lane_w = rdata;
    assign word_s = rdata;
    assign word_u = rdata;
  end

  always_comb begin
    ext_data = rdata;
    case (ld_op)
      LD_B:    ext_data = {{(DATA_W-8){lane_b[7]}}, lane_b};
      LD_BU:   ext_data = {{(DATA_W-8){1'b0}}, lane_b};
      LD_H:    ext_data = {{(DATA_W-16){lane_h[15]}}, lane_h};
      LD_HU:   ext_data = {{(DATA_W-16){1'b0}}, lane_h};
      LD_W:    ext_data = word_s;
      LD_WU:   ext_data = word_u;
      default: ext_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: elastic register that holds loads until the data-memory
// response arrives. Define MEM_STAGE_LD_EXT_EN to enable sub-word alignment and extension.
module mem_stage
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned PC_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_to_mem_valid,
  output logic              o_mem_ready,
  output logic              mem_to_wb_valid,
  input  logic              i_wb_ready,
  input  logic              ex_to_mem_mem_re,
  input  logic [2:0]        ex_to_mem_ld_op,
  input  logic [DATA_W-1:0] ex_to_mem_alu_res,
  input  logic [REG_AW-1:0] ex_to_mem_rf_waddr,
  input  logic              ex_to_mem_rf_we,
  input  logic [PC_W-1:0]   ex_to_mem_pc,
  input  logic [PC_W-1:0]   ex_to_mem_inst,
  input  logic              dmem_rdata_valid,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              mem_to_wb_mem_re,
  output logic [DATA_W-1:0] mem_to_wb_rf_wdata,
  output logic [REG_AW-1:0] mem_to_wb_rf_waddr,
  output logic              mem_to_wb_rf_we,
  output logic [PC_W-1:0]   mem_to_wb_pc,
  output logic [PC_W-1:0]   mem_to_wb_inst
);

  localparam int unsigned OffW = $clog2(DATA_W / 8);

  mem_state_e        state_q;
  logic              mem_re_q;
  logic [DATA_W-1:0] alu_res_q;
  logic [DATA_W-1:0] rdata_q;
  logic [REG_AW-1:0] waddr_q;
  logic              we_q;
  logic [PC_W-1:0]   pc_q;
  logic [PC_W-1:0]   inst_q;
  logic [DATA_W-1:0] load_data;
  logic              accept;

  assign o_mem_ready = (state_q == EMPTY) || ((state_q == FULL) && i_wb_ready);
  assign accept      = ex_to_mem_valid && o_mem_ready;

  // Retire and accept in the same FULL cycle behave exactly like an accept from EMPTY.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= EMPTY;
      mem_re_q  <= 1'b0;
      alu_res_q <= '0;
      rdata_q   <= '0;
      waddr_q   <= '0;
      we_q      <= 1'b0;
      pc_q      <= '0;
      inst_q    <= '0;
    end else if (accept) begin
      state_q   <= ex_to_mem_mem_re ? WAIT : FULL;
      mem_re_q  <= ex_to_mem_mem_re;
      alu_res_q <= ex_to_mem_alu_res;
      waddr_q   <= ex_to_mem_rf_waddr;
      we_q      <= ex_to_mem_rf_we;
      pc_q      <= ex_to_mem_pc;
      inst_q    <= ex_to_mem_inst;
    end else begin
      case (state_q)
        WAIT: begin
          if (dmem_rdata_valid) begin
            rdata_q <= dmem_rdata;
            state_q <= FULL;
          end
        end
        FULL: begin
          if (i_wb_ready) begin
            state_q <= EMPTY;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_STAGE_LD_EXT_EN
  ld_op_e ld_op_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_op_q <= LD_B;
    end else if (accept) begin
      ld_op_q <= ld_op_e'(ex_to_mem_ld_op);
    end
  end

  ld_align #(
    .DATA_W (DATA_W)
  ) u_ld_align (
    .ld_op    (ld_op_q),
    .addr     (alu_res_q[OffW-1:0]),
    .rdata    (rdata_q),
    .ext_data (load_data)
  );
`else
  logic unused_ld_op;

  assign unused_ld_op = ^ex_to_mem_ld_op;
  assign load_data    = rdata_q;
`endif

  assign mem_to_wb_valid    = (state_q == FULL);
  assign mem_to_wb_mem_re   = mem_re_q;
  assign mem_to_wb_rf_wdata = mem_re_q ? load_data : alu_res_q;
  assign mem_to_wb_rf_waddr = waddr_q;
  assign mem_to_wb_rf_we    = we_q;
  assign mem_to_wb_pc       = pc_q;
  assign mem_to_wb_inst     = inst_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: load vector table plus hand-written handshake/reset sequences.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_to_mem_valid;
  logic        o_mem_ready;
  logic        mem_to_wb_valid;
  logic        i_wb_ready;
  logic        ex_to_mem_mem_re;
  logic [2:0]  ex_to_mem_ld_op;
  logic [31:0] ex_to_mem_alu_res;
  logic [4:0]  ex_to_mem_rf_waddr;
  logic        ex_to_mem_rf_we;
  logic [31:0] ex_to_mem_pc;
  logic [31:0] ex_to_mem_inst;
  logic        dmem_rdata_valid;
  logic [31:0] dmem_rdata;
  logic        mem_to_wb_mem_re;
  logic [31:0] mem_to_wb_rf_wdata;
  logic [4:0]  mem_to_wb_rf_waddr;
  logic        mem_to_wb_rf_we;
  logic [31:0] mem_to_wb_pc;
  logic [31:0] mem_to_wb_inst;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_stage #(
    .DATA_W (32),
    .REG_AW (5),
    .PC_W   (32)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .ex_to_mem_valid    (ex_to_mem_valid),
    .o_mem_ready        (o_mem_ready),
    .mem_to_wb_valid    (mem_to_wb_valid),
    .i_wb_ready         (i_wb_ready),
    .ex_to_mem_mem_re   (ex_to_mem_mem_re),
    .ex_to_mem_ld_op    (ex_to_mem_ld_op),
    .ex_to_mem_alu_res  (ex_to_mem_alu_res),
    .ex_to_mem_rf_waddr (ex_to_mem_rf_waddr),
    .ex_to_mem_rf_we    (ex_to_mem_rf_we),
    .ex_to_mem_pc       (ex_to_mem_pc),
    .ex_to_mem_inst     (ex_to_mem_inst),
    .dmem_rdata_valid   (dmem_rdata_valid),
    .dmem_rdata         (dmem_rdata),
    .mem_to_wb_mem_re   (mem_to_wb_mem_re),
    .mem_to_wb_rf_wdata (mem_to_wb_rf_wdata),
    .mem_to_wb_rf_waddr (mem_to_wb_rf_waddr),
    .mem_to_wb_rf_we    (mem_to_wb_rf_we),
    .mem_to_wb_pc       (mem_to_wb_pc),
    .mem_to_wb_inst     (mem_to_wb_inst)
  );

  typedef struct {
    logic [2:0]  ld_op;
    logic [31:0] addr;
    logic [31:0] rdata;
    int          lat;
    logic [31:0] exp_ext;
  } ld_vec_t;

  ld_vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    ex_to_mem_valid    = 1'b0;
    ex_to_mem_mem_re   = 1'b0;
    ex_to_mem_ld_op    = 3'd0;
    ex_to_mem_alu_res  = 32'h0;
    ex_to_mem_rf_waddr = 5'd0;
    ex_to_mem_rf_we    = 1'b0;
    ex_to_mem_pc       = 32'h0;
    ex_to_mem_inst     = 32'h0;
    dmem_rdata_valid   = 1'b0;
    dmem_rdata         = 32'h0;
  endtask

  task automatic drive_op(input logic re, input logic [2:0] op, input logic [31:0] alu,
                          input logic [4:0] wa);
    ex_to_mem_valid    = 1'b1;
    ex_to_mem_mem_re   = re;
    ex_to_mem_ld_op    = op;
    ex_to_mem_alu_res  = alu;
    ex_to_mem_rf_waddr = wa;
    ex_to_mem_rf_we    = 1'b1;
    ex_to_mem_pc       = 32'h1000_0000 | alu;
    ex_to_mem_inst     = 32'hA000_0000 | alu;
  endtask

  function automatic logic [31:0] pick(input ld_vec_t v);
`ifdef MEM_STAGE_LD_EXT_EN
    return v.exp_ext;
`else
    return v.rdata;
`endif
  endfunction

  initial begin
    // {ld_op, addr, rdata, response latency, extended result}
    vecs[0] = '{3'd0, 32'h0000_1003, 32'h80FF_FF7F, 3, 32'hFFFF_FF80};
    vecs[1] = '{3'd5, 32'h0000_2002, 32'hBEEF_1234, 1, 32'h0000_BEEF};
    vecs[2] = '{3'd1, 32'h0000_2002, 32'hBEEF_1234, 0, 32'hFFFF_BEEF};
    vecs[3] = '{3'd2, 32'h0000_2002, 32'hBEEF_1234, 2, 32'hBEEF_1234};
    vecs[4] = '{3'd4, 32'h0000_1003, 32'h80FF_FF7F, 0, 32'h0000_0080};
    vecs[5] = '{3'd0, 32'h0000_1000, 32'h80FF_FF7F, 1, 32'h0000_007F};
    vecs[6] = '{3'd0, 32'h0000_1001, 32'h80FF_FF7F, 0, 32'hFFFF_FFFF};
    vecs[7] = '{3'd1, 32'h0000_2001, 32'hBEEF_9234, 0, 32'hFFFF_9234};
    vecs[8] = '{3'd3, 32'h0000_3000, 32'h8765_4321, 0, 32'h8765_4321};
    vecs[9] = '{3'd6, 32'h0000_3004, 32'hF000_000F, 1, 32'hF000_000F};

    drive_idle();
    i_wb_ready = 1'b1;
    rst = 1'b0;
    #12;
    chk("rst_valid", {31'b0, mem_to_wb_valid}, 32'h0);
    chk("rst_we", {31'b0, mem_to_wb_rf_we}, 32'h0);
    chk("rst_mem_re", {31'b0, mem_to_wb_mem_re}, 32'h0);
    chk("rst_wdata", mem_to_wb_rf_wdata, 32'h0);
    chk("rst_waddr", {27'b0, mem_to_wb_rf_waddr}, 32'h0);
    chk("rst_pc", mem_to_wb_pc, 32'h0);
    chk("rst_inst", mem_to_wb_inst, 32'h0);
    rst = 1'b1;
    tick();
    chk("rst_ready", {31'b0, o_mem_ready}, 32'h1);

    // Back-to-back non-loads with writeback always ready.
    drive_op(1'b0, 3'd0, 32'h11, 5'd1);
    #1 chk("b2b_ready0", {31'b0, o_mem_ready}, 32'h1);
    tick();
    chk("b2b_valid1", {31'b0, mem_to_wb_valid}, 32'h1);
    chk("b2b_wdata1", mem_to_wb_rf_wdata, 32'h11);
    chk("b2b_pc1", mem_to_wb_pc, 32'h1000_0011);
    drive_op(1'b0, 3'd0, 32'h22, 5'd2);
    #1 chk("b2b_ready1", {31'b0, o_mem_ready}, 32'h1);
    tick();
    chk("b2b_valid2", {31'b0, mem_to_wb_valid}, 32'h1);
    chk("b2b_wdata2", mem_to_wb_rf_wdata, 32'h22);
    chk("b2b_waddr2", {27'b0, mem_to_wb_rf_waddr}, 32'h2);
    drive_op(1'b0, 3'd0, 32'h33, 5'd3);
    #1 chk("b2b_ready2", {31'b0, o_mem_ready}, 32'h1);
    tick();
    chk("b2b_valid3", {31'b0, mem_to_wb_valid}, 32'h1);
    chk("b2b_wdata3", mem_to_wb_rf_wdata, 32'h33);
    chk("b2b_inst3", mem_to_wb_inst, 32'hA000_0033);
    drive_idle();
    tick();
    chk("b2b_drain", {31'b0, mem_to_wb_valid}, 32'h0);

    // Load table; a response coincident with the accept carries junk and must be ignored.
    for (int i = 0; i < 10; i++) begin
      drive_op(1'b1, vecs[i].ld_op, vecs[i].addr, 5'(i + 4));
      dmem_rdata_valid = 1'b1;
      dmem_rdata       = ~vecs[i].rdata;
      tick();
      drive_idle();
      for (int k = 0; k < vecs[i].lat; k++) begin
        #1 chk($sformatf("ld%0d_wait_ready", i), {31'b0, o_mem_ready}, 32'h0);
        chk($sformatf("ld%0d_wait_valid", i), {31'b0, mem_to_wb_valid}, 32'h0);
        tick();
      end
      dmem_rdata_valid = 1'b1;
      dmem_rdata       = vecs[i].rdata;
      #1 chk($sformatf("ld%0d_resp_ready", i), {31'b0, o_mem_ready}, 32'h0);
      chk($sformatf("ld%0d_resp_valid", i), {31'b0, mem_to_wb_valid}, 32'h0);
      tick();
      drive_idle();
      chk($sformatf("ld%0d_valid", i), {31'b0, mem_to_wb_valid}, 32'h1);
      chk($sformatf("ld%0d_wdata", i), mem_to_wb_rf_wdata, pick(vecs[i]));
      chk($sformatf("ld%0d_mem_re", i), {31'b0, mem_to_wb_mem_re}, 32'h1);
      chk($sformatf("ld%0d_waddr", i), {27'b0, mem_to_wb_rf_waddr}, 32'(i + 4));
      tick();
      chk($sformatf("ld%0d_retired", i), {31'b0, mem_to_wb_valid}, 32'h0);
    end

    // Writeback stall with a new instruction waiting, plus a stray response in FULL.
    drive_op(1'b0, 3'd0, 32'h55, 5'd9);
    tick();
    drive_op(1'b0, 3'd0, 32'h66, 5'd10);
    i_wb_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      dmem_rdata_valid = (k == 2);
      dmem_rdata       = 32'hDEAD_BEEF;
      #1 chk($sformatf("stall%0d_ready", k), {31'b0, o_mem_ready}, 32'h0);
      chk($sformatf("stall%0d_valid", k), {31'b0, mem_to_wb_valid}, 32'h1);
      chk($sformatf("stall%0d_wdata", k), mem_to_wb_rf_wdata, 32'h55);
      chk($sformatf("stall%0d_waddr", k), {27'b0, mem_to_wb_rf_waddr}, 32'h9);
      chk($sformatf("stall%0d_mem_re", k), {31'b0, mem_to_wb_mem_re}, 32'h0);
      tick();
    end
    dmem_rdata_valid = 1'b0;
    i_wb_ready = 1'b1;
    #1 chk("release_ready", {31'b0, o_mem_ready}, 32'h1);
    tick();
    drive_idle();
    chk("handover_valid", {31'b0, mem_to_wb_valid}, 32'h1);
    chk("handover_wdata", mem_to_wb_rf_wdata, 32'h66);
    chk("handover_waddr", {27'b0, mem_to_wb_rf_waddr}, 32'hA);
    tick();
    chk("handover_drain", {31'b0, mem_to_wb_valid}, 32'h0);

    // Stray response in EMPTY.
    dmem_rdata_valid = 1'b1;
    dmem_rdata       = 32'h1234_5678;
    tick();
    dmem_rdata_valid = 1'b0;
    chk("stray_empty_valid", {31'b0, mem_to_wb_valid}, 32'h0);
    #1 chk("stray_empty_ready", {31'b0, o_mem_ready}, 32'h1);
    chk("stray_empty_wdata", mem_to_wb_rf_wdata, 32'h66);

    // Reset during WAIT drops the load; a late response is ignored.
    drive_op(1'b1, 3'd2, 32'h4000, 5'd12);
    tick();
    drive_idle();
    #1 chk("rw_wait_ready", {31'b0, o_mem_ready}, 32'h0);
    rst = 1'b0;
    #1 chk("rw_rst_ready", {31'b0, o_mem_ready}, 32'h1);
    chk("rw_rst_mem_re", {31'b0, mem_to_wb_mem_re}, 32'h0);
    tick();
    rst = 1'b1;
    dmem_rdata_valid = 1'b1;
    dmem_rdata       = 32'hCAFE_F00D;
    tick();
    dmem_rdata_valid = 1'b0;
    chk("rw_late_valid", {31'b0, mem_to_wb_valid}, 32'h0);
    chk("rw_late_wdata", mem_to_wb_rf_wdata, 32'h0);
    #1 chk("rw_late_ready", {31'b0, o_mem_ready}, 32'h1);
    tick();
    chk("rw_final_valid", {31'b0, mem_to_wb_valid}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Parametrised memory-access pipeline stage between execute and writeback.
- Adds a three-state elastic register with a valid/ready handshake on both sides.
- Waits for a variable-latency data-memory response before presenting a load to writeback; stalls upstream only while a load is pending or writeback is stalled.
- Aligns and sign/zero-extends sub-word load data.
- Provides the same-cycle bypass value to the execute-stage forwarding network.

## Interface
Parameters:
- DATA_W, 32, register/data width; legal values 32 or 64.
- REG_AW, 5, register-file address width.
- PC_W, 32, PC and instruction width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- ex_to_mem_valid  in  1  execute presents an instruction.
- o_mem_ready  out  1  stage accepts from execute this cycle.
- mem_to_wb_valid  out  1  stage presents a result to writeback.
- i_wb_ready  in  1  writeback accepts this cycle.
- ex_to_mem_mem_re  in  1  instruction is a load.
- ex_to_mem_ld_op  in  3  load kind: 0 B, 1 H, 2 W, 3 D, 4 BU, 5 HU, 6 WU.
- ex_to_mem_alu_res  in  DATA_W  ALU result or load address.
- ex_to_mem_rf_waddr  in  REG_AW  destination register.
- ex_to_mem_rf_we  in  1  register write enable.
- ex_to_mem_pc, ex_to_mem_inst  in  PC_W  trace fields.
- dmem_rdata_valid  in  1  data-memory response strobe.
- dmem_rdata  in  DATA_W  raw response word.
- mem_to_wb_mem_re  out  1  registered load flag (bypass).
- mem_to_wb_rf_wdata  out  DATA_W  extended load data or ALU result.
- mem_to_wb_rf_waddr  out  REG_AW
- mem_to_wb_rf_we  out  1
- mem_to_wb_pc, mem_to_wb_inst  out  PC_W

## Operation
FSM states:
- EMPTY: no instruction held.
- WAIT: load held, response outstanding.
- FULL: result ready for writeback.

Handshake:
- Accept: ex_to_mem_valid && o_mem_ready.
- o_mem_ready = EMPTY || (FULL && i_wb_ready).
- Retire: FULL && i_wb_ready.

Transitions:
- EMPTY: accept a non-load goes to FULL; accept a load goes to WAIT; otherwise stay in EMPTY.
- WAIT: dmem_rdata_valid captures the raw data into the rdata buffer and goes to FULL; otherwise stay in WAIT.
- FULL: retire plus simultaneous accept behaves like an accept from EMPTY (back-to-back, no bubble); retire alone goes to EMPTY; otherwise hold.

Data rules:
- dmem_rdata_valid in EMPTY or FULL is ignored, with no state change.
- All payload registers load only on accept. They hold while in WAIT and FULL.
- mem_to_wb_valid = FULL.

Extension:
- Lane select uses alu_res[log2(DATA_W/8)-1:0].
- B/BU pick byte lane; H/HU pick half lane using addr[1] (and addr[2] if 64); W/WU pick word lane (addr[2] if 64); D passes through.
- Signed kinds replicate the top bit up to DATA_W; unsigned kinds zero-fill.
- Low address bits below the access size are ignored; misalignment faults are handled upstream.
- D, W, and WU on DATA_W=32: D is treated as W; WU is treated as W.
- mem_to_wb_rf_wdata = mem_re ? extended(rdata buffer) : alu_res.

## Timing
- Reset (asynchronous, active-low):
  - State goes to EMPTY.
  - Outputs: mem_to_wb_valid=0, mem_to_wb_rf_we=0, mem_to_wb_mem_re=0, all data/addr/pc/inst outputs 0, o_mem_ready=1 after release.
  - Reset mid-WAIT drops the pending load; a late response after release is ignored.
- Non-load latency: mem_to_wb_valid is 1 in the cycle after accept.
- Load latency: mem_to_wb_valid is 1 in the cycle after the dmem_rdata_valid cycle. A response in the same cycle as the accept is not seen; the earliest counted response is in the first WAIT cycle.
- Extension is combinational from the registered buffer; no added cycle.
- Throughput: 1 instruction/cycle for non-loads with i_wb_ready held at 1.

## Configuration
- MEM_STAGE_LD_EXT_EN defined: sub-word alignment and extension as above.
- Undefined: ex_to_mem_ld_op is ignored; load data = dmem_rdata unmodified; the extension logic and the ld_op register are removed.

## Structure
- Shared package mem_pkg holds the ld_op_e enum (LD_B..LD_WU) and the mem_state_e enum (EMPTY, WAIT, FULL).
- Sub-module ld_align (combinational, parametrised by DATA_W) performs lane select and extension; it is instantiated only under MEM_STAGE_LD_EXT_EN.

## Test plan
- Non-load, back-to-back: alu_res 0x11, 0x22, 0x33 on consecutive cycles, i_wb_ready=1 -> valid on cycles 1, 2, 3 with wdata 0x11, 0x22, 0x33; o_mem_ready constant at 1.
- Load, 3-cycle response: LD_B at addr 0x1003, dmem_rdata=0x80FF_FF7F returned 3 cycles later -> wdata 0xFFFF_FF80; valid one cycle after the response; o_mem_ready=0 during WAIT.
- LD_HU at addr 0x2002, rdata 0xBEEF_1234 -> 0x0000_BEEF; LD_H same inputs -> 0xFFFF_BEEF; LD_W -> 0xBEEF_1234.
- Writeback stall: FULL with i_wb_ready=0 for 4 cycles -> outputs stable, o_mem_ready=0; release with a new valid input -> handover with no bubble.
- Stray response: dmem_rdata_valid pulses in EMPTY and in FULL -> no state or output change.
- Reset mid-WAIT: rst low for 1 cycle during WAIT, then a response arrives -> state EMPTY, valid stays 0, response ignored.
